// File: rtl/conv_window_feeder.sv
// rtl/conv_window_feeder.sv - 3x3 stride-2 column feeder from a three-port row memory
// Define CONV_SAME_PAD_EN for the ceil(W/2) x ceil(H/2) zero-padded output grid.
module conv_window_feeder #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stall,
  output logic [2:0][MEM_ADDR_W-1:0]     mem_addr,
  input  logic [2:0][DATA_W-1:0]         mem_rdata,
  output logic [2:0][DATA_W-1:0]         out_data,
  output logic                           out_valid,
  output logic [ADDR_W-1:0]              r_addr,
  output logic                           delay,
  output logic                           busy,
  output logic                           done
);

`ifdef CONV_SAME_PAD_EN
  localparam int OUT_W = (IMG_W + 1) / 2;
  localparam int OUT_H = (IMG_H + 1) / 2;
`else
  localparam int OUT_W = (IMG_W - 3) / 2 + 1;
  localparam int OUT_H = (IMG_H - 3) / 2 + 1;
`endif
  localparam int CW_X = $clog2(OUT_W + 1);
  localparam int CW_Y = $clog2(OUT_H + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  k_q, k_d;
  logic [CW_X-1:0]             ox_q, ox_d;
  logic [CW_Y-1:0]             oy_q, oy_d;
  logic [ADDR_W-1:0]           beat_q, beat_d;
  logic                        s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]           s1_beat_q, s1_beat_d;
  logic                        s1_last_q, s1_last_d;
  logic [2:0][DATA_W-1:0]      hold_q, hold_d;
  logic                        hold_v_q, hold_v_d;
  logic [2:0][DATA_W-1:0]      out_data_q, out_data_d;
  logic                        out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]           r_addr_q, r_addr_d;
  logic                        delay_q, delay_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [31:0]                 row_top, col;
  logic [2:0][31:0]            row;
  logic [2:0][MEM_ADDR_W-1:0]  addr_calc;
  logic                        last_beat;
`ifdef CONV_SAME_PAD_EN
  logic [2:0]                  pad;
  logic [2:0]                  s1_pad_q, s1_pad_d;
`endif

  // Port [2] reads the top row of the window, port [0] the bottom row.
  always_comb begin
    row_top = 32'(oy_q) << 1;
    col     = (32'(ox_q) << 1) + 32'(k_q);
    for (int p = 0; p < 3; p++) begin
      row[p]       = row_top + 32'(2 - p);
      addr_calc[p] = MEM_ADDR_W'(row[p] * 32'(IMG_W) + col);
    end
`ifdef CONV_SAME_PAD_EN
    for (int p = 0; p < 3; p++) begin
      pad[p] = (row[p] >= 32'(IMG_H)) || (col >= 32'(IMG_W));
    end
`endif
    for (int p = 0; p < 3; p++) begin
      mem_addr[p] = (state_q == S_RUN) ? addr_calc[p] : '0;
`ifdef CONV_SAME_PAD_EN
      if (pad[p]) mem_addr[p] = '0;
`endif
    end
  end

  assign last_beat = (k_q == 2'd2) && (ox_q == CW_X'(OUT_W - 1)) && (oy_q == CW_Y'(OUT_H - 1));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ox_d        = ox_q;
    oy_d        = oy_q;
    beat_d      = beat_q;
    s1_valid_d  = s1_valid_q;
    s1_beat_d   = s1_beat_q;
    s1_last_d   = s1_last_q;
    hold_d      = hold_q;
    hold_v_d    = hold_v_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    r_addr_d    = r_addr_q;
    delay_d     = delay_q;
    busy_d      = busy_q;
    done_d      = done_q;
`ifdef CONV_SAME_PAD_EN
    s1_pad_d    = s1_pad_q;
`endif
    if (stall) begin
      // The memory answers the held address on the next cycle, so keep the
      // in-flight read from before the stall in a side register.
      if (!hold_v_q) begin
        hold_d   = mem_rdata;
        hold_v_d = 1'b1;
      end
    end else begin
      hold_v_d    = 1'b0;
      out_valid_d = s1_valid_q;
      r_addr_d    = s1_valid_q ? s1_beat_q : '0;
      delay_d     = s1_valid_q & s1_last_q;
      for (int p = 0; p < 3; p++) begin
        out_data_d[p] = !s1_valid_q ? '0 : (hold_v_q ? hold_q[p] : mem_rdata[p]);
`ifdef CONV_SAME_PAD_EN
        if (s1_pad_q[p]) out_data_d[p] = '0;
`endif
      end

      s1_valid_d = (state_q == S_RUN);
      s1_beat_d  = (state_q == S_RUN) ? beat_q + ADDR_W'(1) : '0;
      s1_last_d  = (state_q == S_RUN) && (k_q == 2'd2);
`ifdef CONV_SAME_PAD_EN
      s1_pad_d   = (state_q == S_RUN) ? pad : 3'b000;
`endif

      case (state_q)
        S_IDLE: begin
          k_d    = '0;
          ox_d   = '0;
          oy_d   = '0;
          beat_d = '0;
          if (start) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
        S_RUN: begin
          beat_d = beat_q + ADDR_W'(1);
          if (k_q == 2'd2) begin
            k_d = '0;
            if (ox_q == CW_X'(OUT_W - 1)) begin
              ox_d = '0;
              oy_d = (oy_q == CW_Y'(OUT_H - 1)) ? '0 : oy_q + CW_Y'(1);
            end else begin
              ox_d = ox_q + CW_X'(1);
            end
          end else begin
            k_d = k_q + 2'd1;
          end
          if (last_beat) state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (!s1_valid_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      beat_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_beat_q   <= '0;
      s1_last_q   <= 1'b0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      r_addr_q    <= '0;
      delay_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef CONV_SAME_PAD_EN
      s1_pad_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ox_q        <= ox_d;
      oy_q        <= oy_d;
      beat_q      <= beat_d;
      s1_valid_q  <= s1_valid_d;
      s1_beat_q   <= s1_beat_d;
      s1_last_q   <= s1_last_d;
      hold_q      <= hold_d;
      hold_v_q    <= hold_v_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      r_addr_q    <= r_addr_d;
      delay_q     <= delay_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef CONV_SAME_PAD_EN
      s1_pad_q    <= s1_pad_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign r_addr    = r_addr_q;
  assign delay     = delay_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// tb/tb_conv_window_feeder.sv - directed bench for conv_window_feeder (default 28x28 valid-only grid)
module tb_conv_window_feeder;
  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int MW    = 10;
  localparam int BEATS = 507;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  stall = 1'b0;
  logic [2:0][MW-1:0]    mem_addr;
  logic [2:0][DW-1:0]    mem_rdata;
  logic [2:0][DW-1:0]    out_data;
  logic                  out_valid;
  logic [AW-1:0]         r_addr;
  logic                  delay;
  logic                  busy;
  logic                  done;

  int n_cmp = 0;
  int n_bad = 0;

  conv_window_feeder #(
    .IMG_W(28), .IMG_H(28), .DATA_W(DW), .ADDR_W(AW), .MEM_ADDR_W(MW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .r_addr(r_addr),
    .delay(delay), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory holding mem[a] = a on every port.
  always @(posedge clock) begin
    for (int p = 0; p < 3; p++) mem_rdata[p] <= DW'(mem_addr[p]);
  end

  logic [2:0][DW-1:0] col_at [0:1023];
  logic               dly_at [0:1023];
  int beats, raw_valid, order_err, hold_err, done_cnt, start_ign_err, reset_err;
  logic done_busy, done_after_last, busy_after_start, finished;

  function automatic logic [2:0][DW-1:0] model_col(input int b);
    int i, base;
    i    = b - 1;
    base = 2 * ((i / 3) / 13) * 28 + 2 * ((i / 3) % 13) + (i % 3);
    return {DW'(base), DW'(base + 28), DW'(base + 56)};
  endfunction

  task automatic run_frame(input int stall_beat, input int stall_len, input int reset_beat);
    int prev_r, stall_left, post;
    bit stalled, poked, prev_last;
    logic [2:0][DW-1:0] held;
    for (int i = 0; i < 1024; i++) begin col_at[i] = '1; dly_at[i] = 1'bx; end
    beats = 0; raw_valid = 0; order_err = 0; hold_err = 0; done_cnt = 0;
    start_ign_err = 0; reset_err = 0; done_busy = 1'b1; done_after_last = 1'b0;
    prev_r = 0; stall_left = 0; post = 0; stalled = 0; poked = 0; prev_last = 0;
    held = '0; finished = 1'b0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    busy_after_start = busy;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      if (start) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_busy = busy;
        done_after_last = prev_last && !out_valid;
        start = 1'b1;
      end
      if (post > 0 && busy) start_ign_err++;
      prev_last = out_valid && (r_addr == AW'(BEATS));
      if (stall) begin
        if (!out_valid || r_addr != AW'(stall_beat) || out_data != held) hold_err++;
        stall_left--;
        if (stall_left == 0) stall = 1'b0;
      end
      if (out_valid) begin
        raw_valid++;
        if (r_addr != AW'(prev_r)) begin
          if (r_addr != AW'(prev_r + 1)) order_err++;
          beats++;
          prev_r = int'(r_addr);
          col_at[r_addr] = out_data;
          dly_at[r_addr] = delay;
        end
      end
      if (!stalled && stall_len > 0 && out_valid && r_addr == AW'(stall_beat)) begin
        stall = 1'b1; stall_left = stall_len; held = out_data; stalled = 1;
      end
      if (!poked && out_valid && r_addr == AW'(100)) begin
        start = 1'b1; poked = 1;
      end
      if (reset_beat > 0 && out_valid && r_addr == AW'(reset_beat)) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        if (out_valid || busy || done || delay || r_addr != '0 || out_data != '0 || mem_addr != '0)
          reset_err++;
        for (int j = 0; j < 20; j++) begin
          @(negedge clock);
          if (out_valid || busy || done) reset_err++;
        end
        finished = 1'b1;
      end
      if (done_cnt > 0) post++;
      if (post > 3) finished = 1'b1;
      if (!finished) @(negedge clock);
    end
    start = 1'b0;
    stall = 1'b0;
    n_cmp++;
    if (!finished) begin
      n_bad++;
      $display("FAIL frame_timeout: frame did not complete, beats=%0d required %0d", beats, BEATS);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || delay !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b delay=%b required all 0", out_valid, busy, done, delay);
    end
    n_cmp++;
    if (r_addr !== '0 || out_data !== '0 || mem_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_values: r_addr=%0d out_data=%h mem_addr=%h required 0", r_addr, out_data, mem_addr);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_col(input string name, input int b, input logic [2:0][DW-1:0] exp_col, input logic exp_dly);
    n_cmp++;
    if (col_at[b] !== exp_col || dly_at[b] !== exp_dly) begin
      n_bad++;
      $display("FAIL %s: beat %0d data={%0d,%0d,%0d} delay=%b required {%0d,%0d,%0d} delay=%b", name, b,
               col_at[b][2], col_at[b][1], col_at[b][0], dly_at[b], exp_col[2], exp_col[1], exp_col[0], exp_dly);
    end
  endtask

  task automatic test_frame;
    int merr;
    run_frame(0, 0, 0);
    n_cmp++;
    if (busy_after_start !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start: busy=%b required 1", busy_after_start);
    end
    check_col("beat1",   1,   {16'd0, 16'd28, 16'd56},     1'b0);
    check_col("beat3",   3,   {16'd2, 16'd30, 16'd58},     1'b1);
    check_col("beat4",   4,   {16'd2, 16'd30, 16'd58},     1'b0);
    check_col("beat40",  40,  {16'd56, 16'd84, 16'd112},   1'b0);
    check_col("beat507", 507, {16'd698, 16'd726, 16'd754}, 1'b1);
    merr = 0;
    for (int b = 1; b <= BEATS; b++) begin
      if (col_at[b] !== model_col(b) || dly_at[b] !== ((b % 3) == 0)) merr++;
    end
    n_cmp++;
    if (merr != 0) begin
      n_bad++;
      $display("FAIL frame_model: %0d beats differ, required 0", merr);
    end
    n_cmp++;
    if (beats != BEATS || raw_valid != BEATS || order_err != 0) begin
      n_bad++;
      $display("FAIL frame_count: beats=%0d valid_cycles=%0d order_err=%0d required %0d/%0d/0", beats, raw_valid, order_err, BEATS, BEATS);
    end
    n_cmp++;
    if (done_cnt != 1 || done_busy !== 1'b0 || done_after_last !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_done: done_cnt=%0d busy_at_done=%b after_last=%b required 1/0/1", done_cnt, done_busy, done_after_last);
    end
    n_cmp++;
    if (start_ign_err != 0) begin
      n_bad++;
      $display("FAIL start_on_done: busy rose %0d times after done, required 0", start_ign_err);
    end
  endtask

  task automatic test_stall;
    run_frame(10, 5, 0);
    n_cmp++;
    if (hold_err != 0) begin
      n_bad++;
      $display("FAIL stall_hold: %0d stalled cycles moved, required 0", hold_err);
    end
    n_cmp++;
    if (beats != BEATS || raw_valid != BEATS + 5 || order_err != 0) begin
      n_bad++;
      $display("FAIL stall_count: beats=%0d valid_cycles=%0d order_err=%0d required %0d/%0d/0", beats, raw_valid, order_err, BEATS, BEATS + 5);
    end
    check_col("stall_beat10", 10, {16'd6, 16'd34, 16'd62}, 1'b0);
    check_col("stall_beat11", 11, {16'd7, 16'd35, 16'd63}, 1'b0);
    check_col("stall_beat12", 12, {16'd8, 16'd36, 16'd64}, 1'b1);
    n_cmp++;
    if (done_cnt != 1) begin
      n_bad++;
      $display("FAIL stall_done: done_cnt=%0d required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    run_frame(0, 0, 200);
    n_cmp++;
    if (reset_err != 0 || done_cnt != 0) begin
      n_bad++;
      $display("FAIL reset_mid: reset_err=%0d done_cnt=%0d required 0/0", reset_err, done_cnt);
    end
    run_frame(0, 0, 0);
    check_col("restart_beat1", 1, {16'd0, 16'd28, 16'd56}, 1'b0);
    n_cmp++;
    if (beats != BEATS || order_err != 0 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL restart_count: beats=%0d order_err=%0d done_cnt=%0d required %0d/0/1", beats, order_err, done_cnt, BEATS);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
